// File: rtl/mips_alu_pkg.sv
// Shared EX-stage definitions: ALU opcodes, datapath width and the
// multiply-sequencer state encoding.
package mips_alu_pkg;

  // Datapath width W of the ALU and the multiply sequencer.
  localparam int ALU_W = 32;

  // ALU opcodes.
  localparam logic [3:0] ALU_SLL = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_LUI = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1111;

  // Multiply sequencer states.
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'b00,
    SEQ_STEP = 2'b01,
    SEQ_DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-and-add multiplier producing the low W bits of op_a*op_b.
// Each partial-product add is done by the shared EX-stage ALU, borrowed
// one cycle at a time through the alu_req/alu_gnt handshake.
module alu_mul_seq
  import mips_alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         alu_req,
  input  logic         alu_gnt,
  output logic [3:0]   alu_ctrl,
  output logic [W-1:0] alu_data1,
  output logic [W-1:0] alu_data2,
  output logic [5:0]   alu_shamt,
  input  logic [W-1:0] alu_res
);

  // Step index of the final iteration; the counter is 6 bits wide.
  localparam logic [5:0] LAST_STEP = 6'(W - 1);

  seq_state_e   state_q,  state_d;
  logic [W-1:0] acc_q,    acc_d;
  logic [W-1:0] mcand_q,  mcand_d;
  logic [W-1:0] mplier_q, mplier_d;
  logic [W-1:0] result_q, result_d;
  logic [5:0]   cnt_q,    cnt_d;
  logic [W-1:0] mplier_shr;

  // ALU-facing outputs decode from registered state only, never from
  // alu_gnt, so the EX operand mux cannot close a combinational loop.
  always_comb begin
    busy      = (state_q == SEQ_STEP);
    done      = (state_q == SEQ_DONE);
    alu_req   = (state_q == SEQ_STEP);
    alu_ctrl  = alu_req ? ALU_ADD : 4'b0000;
    alu_data1 = alu_req ? acc_q : '0;
    alu_data2 = (alu_req && mplier_q[0]) ? mcand_q : '0;
    alu_shamt = 6'd0;
    result    = result_q;
  end

  // Next-state and datapath update: one shift-and-add step per granted cycle.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    mplier_shr = mplier_q >> 1;

    case (state_q)
      SEQ_STEP: begin
        // Without a grant the ALU belongs to the pipeline: hold everything.
        if (alu_gnt) begin
          acc_d    = alu_res;
          mcand_d  = {mcand_q[W-2:0], 1'b0};
          mplier_d = mplier_shr;
          cnt_d    = cnt_q + 6'd1;
          if (mplier_shr == '0 || cnt_q == LAST_STEP) begin
            state_d  = SEQ_DONE;
            result_d = alu_res;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    // A new multiply is accepted from IDLE and also straight out of DONE,
    // giving back-to-back operation with no idle bubble.
    if (start && state_q != SEQ_STEP) begin
      acc_d    = '0;
      mcand_d  = op_a;
      mplier_d = op_b;
      cnt_d    = 6'd0;
      result_d = '0;
      state_d  = (op_b != '0) ? SEQ_STEP : SEQ_DONE;
    end
  end

  // State registers with synchronous active-low reset; an aborted
  // operation leaves no trace and produces no done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q  <= SEQ_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= 6'd0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq. The driver pushes the expected product
// and step count for every accepted start; a negedge monitor pops on done and
// checks the result and the latency (steps + stalls + 1).
module tb_alu_mul_seq;

  typedef struct {
    logic [31:0] prod;
    int          k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_req;
  logic        alu_gnt = 1'b0;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [5:0]  alu_shamt;
  logic [31:0] alu_res;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  logic gnt_rand  = 1'b0;
  logic gnt_fixed = 1'b1;

  alu_mul_seq #(.W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .alu_req   (alu_req),
    .alu_gnt   (alu_gnt),
    .alu_ctrl  (alu_ctrl),
    .alu_data1 (alu_data1),
    .alu_data2 (alu_data2),
    .alu_shamt (alu_shamt),
    .alu_res   (alu_res)
  );

  always #5 clk = ~clk;

  // Shared ALU: adds when granted to the sequencer; otherwise the EX mux
  // would present a pipeline result, modelled here as junk.
  assign alu_res = !alu_gnt ? (alu_data1 ^ 32'hDEAD_BEEF) :
                   (alu_ctrl == 4'b0001) ? alu_data1 + alu_data2 : 32'h0;

  // Grant driver, updated 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    alu_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : gnt_fixed;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of shift-and-add steps: position of the highest set bit plus one.
  function automatic int steps_for(input logic [31:0] b);
    int k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  // Present a start for one cycle; expectation is pushed only if accepted.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] p;
    p = a * b;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    if (!busy) begin
      e.prod = p;
      e.k    = steps_for(b);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy || done) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("drain_timeout_pending", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: interface invariants every cycle, scoreboard pop on done.
  int   since     = 0;
  int   stalls    = 0;
  logic req_seen  = 1'b0;
  logic in_flight = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    since++;
    check("req_eq_busy", 64'(alu_req), 64'(busy));
    check("alu_ctrl", 64'(alu_ctrl), alu_req ? 64'd1 : 64'd0);
    check("alu_shamt", 64'(alu_shamt), 64'd0);
    if (alu_req) req_seen = 1'b1;
    if (alu_req && !alu_gnt) stalls++;
    if (!rst_n) in_flight = 1'b0;
    if (done) begin
      if (sb.size() == 0 || !in_flight) begin
        check("done_without_accepted_op", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.prod));
        check("done_latency", 64'(since), 64'(e.k + 1 + stalls));
        if (e.k == 0) check("req_for_zero_multiplier", 64'(req_seen), 64'd0);
        in_flight = 1'b0;
      end
    end
    if (rst_n && start && !busy) begin
      since     = 0;
      stalls    = 0;
      req_seen  = 1'b0;
      in_flight = 1'b1;
    end
  end

  initial begin
    logic [31:0] d1, d2, a, b;
    int          n;

    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_data1", 64'(alu_data1), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic products with grant held high.
    issue(32'd7, 32'd6);
    drain();
    issue(32'h1234, 32'd0);
    drain();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // Stall: grant for the first step, withheld for five cycles.
    issue(32'd3, 32'd5);
    @(posedge clk); #1;
    gnt_fixed = 1'b0;
    @(negedge clk);
    d1 = alu_data1;
    d2 = alu_data2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check("stall_acc_hold", 64'(alu_data1), 64'(d1));
      check("stall_operand_hold", 64'(alu_data2), 64'(d2));
    end
    @(posedge clk); #1;
    gnt_fixed = 1'b1;
    drain();

    // Start while busy is ignored; start in the DONE cycle is accepted.
    issue(32'd2, 32'd4);
    issue(32'd9, 32'd9);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("wait_done_timeout", 64'(done), 64'd1);
    issue(32'd5, 32'd3);
    drain();

    // Reset during the second step aborts with no done pulse.
    issue(32'd4, 32'hFF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_req", 64'(alu_req), 64'd0);
    check("abort_data1", 64'(alu_data1), 64'd0);
    check("abort_data2", 64'(alu_data2), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    repeat (12) @(posedge clk);
    #1;

    // Random traffic with random grants; starts may land while busy.
    gnt_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = $urandom;
        b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
        issue(a, b);
      end else begin
        @(posedge clk); #1;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
